// File: rtl/remote_mole_player.sv
// Purpose : host-side whack-a-mole player; decodes game bytes from uart_rx, sends S/H via uart_tx.
// Latency : decoded byte effects visible 1 cycle after rx_ready; H issued REACT_CYCLES+1 after a mole byte.
// Backpr. : sends wait for tx_busy=0; tx_busy ignored on the cycle after tx_start, then waited out.
//
// Ports:
//   clock, reset        : system clock, synchronous active-high reset
//   start_req           : one-cycle start request (honoured in IDLE/DONE only)
//   rx_data, rx_ready   : received byte and its one-cycle strobe
//   tx_busy             : transmitter busy flag
//   tx_start, tx_data   : one-cycle send pulse and held send byte
//   game_running        : high from S issue until R received
//   mole_valid/index    : pending mole report and its index (0-4)
//   hits_acked, misses  : saturating per-game counters
//   proto_error         : one-cycle pulse on an illegal byte during play
module remote_mole_player #(
  parameter int REACT_CYCLES = 50_000_000,
  parameter int ACK_TIMEOUT  = 20_000_000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start_req,
  input  logic [7:0] rx_data,
  input  logic       rx_ready,
  input  logic       tx_busy,
  output logic       tx_start,
  output logic [7:0] tx_data,
  output logic       game_running,
  output logic       mole_valid,
  output logic [2:0] mole_index,
  output logic [7:0] hits_acked,
  output logic [7:0] misses,
  output logic       proto_error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND_START,
    S_WAIT_MOLE,
    S_REACT,
    S_SEND_HIT,
    S_WAIT_ACK,
    S_TX_GUARD,
    S_DONE
  } state_t;

  localparam logic [31:0] REACT_LOAD = 32'(REACT_CYCLES - 1);
  localparam logic [31:0] ACK_LOAD   = 32'(ACK_TIMEOUT - 1);

  state_t      r_state;
  state_t      r_ret;          // state to resume once the transmitter is idle again
  logic        r_guard_first;  // first TX_GUARD cycle: tx_busy not yet valid
  logic [31:0] r_cnt;          // shared reaction / ack-timeout down-counter

  logic        r_tx_start;
  logic [7:0]  r_tx_data;
  logic        r_game_running;
  logic        r_mole_valid;
  logic [2:0]  r_mole_index;
  logic [7:0]  r_hits;
  logic [7:0]  r_misses;
  logic        r_proto_error;

  logic        w_is_mole;
  logic        w_is_ack;
  logic        w_is_over;
  logic        w_is_illegal;
  logic [7:0]  w_hits_inc;
  logic [7:0]  w_misses_inc;
  state_t      w_guard_ret;

  assign w_is_mole    = rx_ready && (rx_data >= 8'h30) && (rx_data <= 8'h34);
  assign w_is_ack     = rx_ready && (rx_data == 8'h48);
  assign w_is_over    = rx_ready && (rx_data == 8'h52);
  assign w_is_illegal = rx_ready && !(w_is_mole || w_is_ack || w_is_over);

  assign w_hits_inc   = (r_hits   == 8'hFF) ? r_hits   : r_hits   + 8'd1;
  assign w_misses_inc = (r_misses == 8'hFF) ? r_misses : r_misses + 8'd1;

  // An echo arriving while still guarding the H send completes the hit,
  // so the guard then returns to WAIT_MOLE instead of WAIT_ACK.
  assign w_guard_ret  = (w_is_ack && r_ret == S_WAIT_ACK) ? S_WAIT_MOLE : r_ret;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_ret          <= S_WAIT_MOLE;
      r_guard_first  <= 1'b0;
      r_cnt          <= '0;
      r_tx_start     <= 1'b0;
      r_tx_data      <= 8'h00;
      r_game_running <= 1'b0;
      r_mole_valid   <= 1'b0;
      r_mole_index   <= 3'd0;
      r_hits         <= 8'd0;
      r_misses       <= 8'd0;
      r_proto_error  <= 1'b0;
    end else begin
      r_tx_start    <= 1'b0;
      r_proto_error <= w_is_illegal && r_game_running;

      case (r_state)
        S_IDLE, S_DONE: begin
          if (start_req) begin
            r_hits       <= 8'd0;
            r_misses     <= 8'd0;
            r_mole_valid <= 1'b0;
            // Send S straight away when the transmitter is free.
            if (!tx_busy) begin
              r_tx_start     <= 1'b1;
              r_tx_data      <= 8'h53;
              r_game_running <= 1'b1;
              r_ret          <= S_WAIT_MOLE;
              r_guard_first  <= 1'b1;
              r_state        <= S_TX_GUARD;
            end else begin
              r_state <= S_SEND_START;
            end
          end
        end

        S_SEND_START: begin
          // R before S has gone out is ignored.
          if (!tx_busy) begin
            r_tx_start     <= 1'b1;
            r_tx_data      <= 8'h53;
            r_game_running <= 1'b1;
            r_ret          <= S_WAIT_MOLE;
            r_guard_first  <= 1'b1;
            r_state        <= S_TX_GUARD;
          end
        end

        S_WAIT_MOLE: begin
          if (w_is_over) begin
            r_state        <= S_DONE;
            r_game_running <= 1'b0;
            r_mole_valid   <= 1'b0;
          end else if (w_is_mole) begin
            r_mole_index <= rx_data[2:0];
            r_mole_valid <= 1'b1;
            r_cnt        <= REACT_LOAD;
            r_state      <= S_REACT;
          end
        end

        S_REACT, S_SEND_HIT: begin
          if (w_is_over) begin
            r_state        <= S_DONE;
            r_game_running <= 1'b0;
            r_mole_valid   <= 1'b0;
          end else if (w_is_mole) begin
            r_mole_index <= rx_data[2:0];
            r_mole_valid <= 1'b1;
            r_cnt        <= REACT_LOAD;
            r_state      <= S_REACT;
          end else if (r_state == S_REACT && r_cnt != 32'd0) begin
            r_cnt <= r_cnt - 32'd1;
          end else if (!tx_busy) begin
            // Reaction expired (or already waiting in SEND_HIT): fire H now.
            r_tx_start    <= 1'b1;
            r_tx_data     <= 8'h48;
            r_mole_valid  <= 1'b0;
            r_cnt         <= ACK_LOAD;
            r_ret         <= S_WAIT_ACK;
            r_guard_first <= 1'b1;
            r_state       <= S_TX_GUARD;
          end else begin
            r_state <= S_SEND_HIT;
          end
        end

        S_WAIT_ACK: begin
          // R takes priority over a simultaneous timeout.
          if (w_is_over) begin
            r_state        <= S_DONE;
            r_game_running <= 1'b0;
            r_mole_valid   <= 1'b0;
          end else if (w_is_ack) begin
            r_hits  <= w_hits_inc;
            r_state <= S_WAIT_MOLE;
          end else if (w_is_mole) begin
            r_misses     <= w_misses_inc;
            r_mole_index <= rx_data[2:0];
            r_mole_valid <= 1'b1;
            r_cnt        <= REACT_LOAD;
            r_state      <= S_REACT;
          end else if (r_cnt == 32'd0) begin
            r_misses <= w_misses_inc;
            r_state  <= S_WAIT_MOLE;
          end else begin
            r_cnt <= r_cnt - 32'd1;
          end
        end

        S_TX_GUARD: begin
          if (w_is_over) begin
            r_state        <= S_DONE;
            r_game_running <= 1'b0;
            r_mole_valid   <= 1'b0;
            r_guard_first  <= 1'b0;
          end else if (w_is_mole) begin
            // A new mole while the H echo is outstanding means that hit was missed.
            if (r_ret == S_WAIT_ACK) begin
              r_misses <= w_misses_inc;
            end
            r_mole_index  <= rx_data[2:0];
            r_mole_valid  <= 1'b1;
            r_cnt         <= REACT_LOAD;
            r_guard_first <= 1'b0;
            r_state       <= S_REACT;
          end else begin
            if (w_is_ack) begin
              r_hits <= w_hits_inc;
            end
            r_ret <= w_guard_ret;
            // Ack timeout starts counting from the H pulse itself.
            if (r_ret == S_WAIT_ACK && r_cnt != 32'd0) begin
              r_cnt <= r_cnt - 32'd1;
            end
            r_guard_first <= 1'b0;
            if (!r_guard_first && !tx_busy) begin
              r_state <= w_guard_ret;
            end
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign tx_start     = r_tx_start;
  assign tx_data      = r_tx_data;
  assign game_running = r_game_running;
  assign mole_valid   = r_mole_valid;
  assign mole_index   = r_mole_index;
  assign hits_acked   = r_hits;
  assign misses       = r_misses;
  assign proto_error  = r_proto_error;

endmodule

// File: tb/tb_remote_mole_player.sv
// Purpose : bench for remote_mole_player with REACT_CYCLES=4, ACK_TIMEOUT=8.
// Latency : expected tx bytes carry the exact cycle their tx_start must appear.
// Backpr. : tx_busy driven by the bench to exercise send stalls.
module tb_remote_mole_player;

  logic       clock;
  logic       reset;
  logic       start_req;
  logic [7:0] rx_data;
  logic       rx_ready;
  logic       tx_busy;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       game_running;
  logic       mole_valid;
  logic [2:0] mole_index;
  logic [7:0] hits_acked;
  logic [7:0] misses;
  logic       proto_error;

  remote_mole_player #(
    .REACT_CYCLES(4),
    .ACK_TIMEOUT (8)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .start_req   (start_req),
    .rx_data     (rx_data),
    .rx_ready    (rx_ready),
    .tx_busy     (tx_busy),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .game_running(game_running),
    .mole_valid  (mole_valid),
    .mole_index  (mole_index),
    .hits_acked  (hits_acked),
    .misses      (misses),
    .proto_error (proto_error)
  );

  typedef struct {
    logic [7:0] dat;
    int         cyc;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  logic prev_tx  = 1'b0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Scoreboard: every tx_start must match the oldest expected byte and cycle.
  always @(negedge clock) begin
    if (reset) begin
      prev_tx = 1'b0;
    end else begin
      if (tx_start) begin
        chk("tx_b2b", {31'd0, prev_tx}, 32'd0);
        if (q.size() == 0) begin
          chk("tx_unexpected", {24'd0, tx_data}, 32'hFFFF);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("tx_byte", {24'd0, tx_data}, {24'd0, e.dat});
          chk("tx_cycle", cyc, e.cyc);
        end
      end
      prev_tx = tx_start;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_ready = 1'b1;
    tick(1);
    rx_ready = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    reset     = 1'b1;
    start_req = 1'b0;
    rx_data   = 8'h00;
    rx_ready  = 1'b0;
    tx_busy   = 1'b0;
    tick(3);

    // Reset state
    chk("rst_tx_start", {31'd0, tx_start}, 32'd0);
    chk("rst_tx_data", {24'd0, tx_data}, 32'd0);
    chk("rst_running", {31'd0, game_running}, 32'd0);
    chk("rst_mole_valid", {31'd0, mole_valid}, 32'd0);
    chk("rst_mole_index", {29'd0, mole_index}, 32'd0);
    chk("rst_hits", {24'd0, hits_acked}, 32'd0);
    chk("rst_misses", {24'd0, misses}, 32'd0);
    chk("rst_proto_err", {31'd0, proto_error}, 32'd0);
    reset = 1'b0;
    tick(1);

    // Start with a simultaneous mole byte: start wins, byte ignored
    n = cyc;
    q.push_back('{8'h53, n + 1});
    start_req = 1'b1;
    rx_data   = 8'h33;
    rx_ready  = 1'b1;
    tick(1);
    start_req = 1'b0;
    rx_ready  = 1'b0;
    chk("start_running", {31'd0, game_running}, 32'd1);
    chk("start_byte_ignored", {31'd0, mole_valid}, 32'd0);
    tick(3);

    // Mole '3' -> H after REACT_CYCLES, echo acked
    n = cyc;
    q.push_back('{8'h48, n + 5});
    send_byte(8'h33);
    chk("m3_index", {29'd0, mole_index}, 32'd3);
    chk("m3_valid", {31'd0, mole_valid}, 32'd1);
    tick(5);
    chk("m3_valid_clr", {31'd0, mole_valid}, 32'd0);
    send_byte(8'h48);
    chk("m3_hits", {24'd0, hits_acked}, 32'd1);
    chk("m3_misses", {24'd0, misses}, 32'd0);
    tick(2);

    // Withheld echo -> miss exactly ACK_TIMEOUT cycles after the H pulse
    n = cyc;
    q.push_back('{8'h48, n + 5});
    send_byte(8'h32);
    tick(11);
    chk("to_early", {24'd0, misses}, 32'd0);
    tick(1);
    chk("to_misses", {24'd0, misses}, 32'd1);
    chk("to_hits", {24'd0, hits_acked}, 32'd1);

    // '1' then '4' two cycles later: one H timed from the '4' (also proves WAIT_MOLE)
    n = cyc;
    send_byte(8'h31);
    tick(1);
    q.push_back('{8'h48, n + 2 + 5});
    send_byte(8'h34);
    chk("relatch_index", {29'd0, mole_index}, 32'd4);
    tick(5);
    send_byte(8'h48);
    chk("relatch_hits", {24'd0, hits_acked}, 32'd2);
    tick(3);

    // Illegal byte during REACT, then R during REACT: no H sent
    send_byte(8'h30);
    send_byte(8'h5A);
    chk("perr_pulse", {31'd0, proto_error}, 32'd1);
    send_byte(8'h52);
    chk("perr_once", {31'd0, proto_error}, 32'd0);
    chk("over_running", {31'd0, game_running}, 32'd0);
    chk("over_mole_valid", {31'd0, mole_valid}, 32'd0);
    chk("over_hits", {24'd0, hits_acked}, 32'd2);
    chk("over_misses", {24'd0, misses}, 32'd1);
    send_byte(8'h5A);
    chk("done_no_perr", {31'd0, proto_error}, 32'd0);
    send_byte(8'h52);
    tick(8);
    chk("done_hits_hold", {24'd0, hits_acked}, 32'd2);

    // Restart from DONE with tx_busy held 100 cycles; R before S is ignored
    tx_busy   = 1'b1;
    start_req = 1'b1;
    tick(1);
    start_req = 1'b0;
    chk("restart_hits_clr", {24'd0, hits_acked}, 32'd0);
    chk("restart_misses_clr", {24'd0, misses}, 32'd0);
    chk("restart_not_running", {31'd0, game_running}, 32'd0);
    tick(10);
    send_byte(8'h52);
    tick(88);
    n = cyc;
    tx_busy = 1'b0;
    q.push_back('{8'h53, n + 1});
    tick(1);
    chk("busy_running", {31'd0, game_running}, 32'd1);
    tick(3);

    // 260 acked hits -> saturation at 255
    for (int i = 0; i < 260; i++) begin
      n = cyc;
      q.push_back('{8'h48, n + 5});
      send_byte(8'h30 + 8'(i % 5));
      tick(5);
      send_byte(8'h48);
      if (i == 100) chk("sat_mid_hits", {24'd0, hits_acked}, 32'd101);
    end
    chk("sat_hits", {24'd0, hits_acked}, 32'd255);
    chk("sat_misses", {24'd0, misses}, 32'd0);

    // Reset while an H is about to fire, transmitter busy
    send_byte(8'h31);
    tick(3);
    reset   = 1'b1;
    tx_busy = 1'b1;
    tick(1);
    chk("mrst_tx_start", {31'd0, tx_start}, 32'd0);
    chk("mrst_tx_data", {24'd0, tx_data}, 32'd0);
    chk("mrst_running", {31'd0, game_running}, 32'd0);
    chk("mrst_hits", {24'd0, hits_acked}, 32'd0);
    chk("mrst_mole_index", {29'd0, mole_index}, 32'd0);
    reset   = 1'b0;
    tx_busy = 1'b0;
    tick(8);
    chk("sb_empty", q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
